// File: rtl/onehot_ring_reader.sv
// onehot_ring_reader: read side of the one-hot ring memory.
// Owns the slot array and per-slot valid bitmap, drains slots in strict
// index order over a valid/ready stream, checks each drained word against
// the one-hot pattern 1<<slot, and flags writes that land on a live slot.
module onehot_ring_reader #(
  parameter int WIDTH     = 6,
  parameter int NUM_ELEMS = 2 ** WIDTH,
  parameter int DWIDTH    = NUM_ELEMS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [WIDTH-1:0]  out_idx,
  output logic [WIDTH:0]    count,
  output logic              err_pattern,
  output logic              err_overwrite
);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  logic [DWIDTH-1:0]    mem [NUM_ELEMS];

  state_t               state_q, state_d;
  logic [NUM_ELEMS-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DWIDTH-1:0]    out_data_q, out_data_d;
  logic [WIDTH:0]       count_q, count_d;
  logic                 err_pattern_q, err_pattern_d;
  logic                 err_overwrite_q, err_overwrite_d;

  logic                 handshake;
  logic                 same_slot;
  logic                 cnt_inc;
  logic                 cnt_dec;
  logic [DWIDTH-1:0]    one_hot;
  logic [WIDTH-1:0]     rd_ptr_inc;

  assign handshake = (state_q == SHOW) && out_ready;
  // A write landing on the slot being consumed this cycle replaces it cleanly.
  assign same_slot = handshake && wr_en && (wr_addr == rd_ptr_q);
  assign one_hot   = DWIDTH'(1) << rd_ptr_q;
  assign rd_ptr_inc = (rd_ptr_q == WIDTH'(NUM_ELEMS - 1)) ? '0 : rd_ptr_q + 1'b1;

  // A write to an empty slot, or to the slot being freed this cycle, adds one.
  assign cnt_inc = wr_en && (!valid_q[wr_addr] || same_slot);
  assign cnt_dec = handshake;

  // Slot storage: plain write port, asynchronous read by the drain logic.
  // NOTE: the array is deliberately left out of reset; the valid bitmap alone
  // says which entries are meaningful, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Next-state, bitmap, counter and error-flag logic.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d         = state_q;
    valid_d         = valid_q;
    rd_ptr_d        = rd_ptr_q;
    out_data_d      = out_data_q;
    count_d         = count_q;
    err_pattern_d   = err_pattern_q;
    err_overwrite_d = err_overwrite_q;

    unique case (state_q)
      IDLE: begin
        if (valid_q[rd_ptr_q]) begin
          out_data_d = mem[rd_ptr_q];
          if (mem[rd_ptr_q] != one_hot) begin
            err_pattern_d = 1'b1;
          end
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (handshake) begin
          valid_d[rd_ptr_q] = 1'b0;
          rd_ptr_d          = rd_ptr_inc;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Applied after the clear so a same-slot write keeps the slot valid.
    if (wr_en) begin
      valid_d[wr_addr] = 1'b1;
      if (valid_q[wr_addr] && !same_slot) begin
        err_overwrite_d = 1'b1;
      end
    end

    unique case ({cnt_inc, cnt_dec})
      2'b10:   count_d = count_q + (WIDTH+1)'(1);
      2'b01:   count_d = count_q - (WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling the pre-edge
    // values, independent of statement order.
    if (rst) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      rd_ptr_q        <= '0;
      out_data_q      <= '0;
      count_q         <= '0;
      err_pattern_q   <= 1'b0;
      err_overwrite_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      rd_ptr_q        <= rd_ptr_d;
      out_data_q      <= out_data_d;
      count_q         <= count_d;
      err_pattern_q   <= err_pattern_d;
      err_overwrite_q <= err_overwrite_d;
    end
  end

  assign out_valid     = (state_q == SHOW);
  assign out_idx       = rd_ptr_q;
  assign out_data      = out_data_q;
  assign count         = count_q;
  assign err_pattern   = err_pattern_q;
  assign err_overwrite = err_overwrite_q;

endmodule

// File: tb/tb_onehot_ring_reader.sv
// Self-checking bench for onehot_ring_reader: directed scenarios plus a
// randomized phase, compared every cycle against a slot-array reference model.
module tb_onehot_ring_reader;

  localparam int W  = 6;
  localparam int N  = 64;
  localparam int DW = 64;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [W-1:0]  wr_addr;
  logic [DW-1:0] wr_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [W-1:0]  out_idx;
  logic [W:0]    count;
  logic          err_pattern;
  logic          err_overwrite;

  onehot_ring_reader #(.WIDTH(W), .NUM_ELEMS(N), .DWIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_idx       (out_idx),
    .count         (count),
    .err_pattern   (err_pattern),
    .err_overwrite (err_overwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: slot contents, live flags, the read position and
  // whether a captured word is currently on offer.
  logic [DW-1:0] m_mem [N];
  bit            m_live [N];
  int            m_ptr;
  bit            m_offer;
  logic [DW-1:0] m_word;
  bit            m_errp;
  bit            m_erro;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int live_slots();
    int n = 0;
    for (int i = 0; i < N; i++) n += m_live[i];
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_live[i] = 1'b0;
    m_ptr = 0; m_offer = 1'b0; m_word = '0; m_errp = 1'b0; m_erro = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare at mid-cycle, advance model and DUT.
  task automatic step(input bit r, input bit we, input int a, input logic [DW-1:0] d, input bit rdy);
    bit take;
    rst = r; wr_en = we; wr_addr = W'(a); wr_data = d; out_ready = rdy;
    #4;
    check("out_valid", 64'(out_valid), 64'(m_offer));
    check("out_idx", 64'(out_idx), 64'(m_ptr));
    check("out_data", out_data, m_word);
    check("count", 64'(count), 64'(live_slots()));
    check("err_pattern", 64'(err_pattern), 64'(m_errp));
    check("err_overwrite", 64'(err_overwrite), 64'(m_erro));
    if (r) begin
      model_reset();
      if (we) m_mem[a] = d;
    end else begin
      take = m_offer && rdy;
      if (we && m_live[a] && !(take && a == m_ptr)) m_erro = 1'b1;
      if (!m_offer && m_live[m_ptr]) begin
        m_word  = m_mem[m_ptr];
        if (m_mem[m_ptr] != (64'd1 << m_ptr)) m_errp = 1'b1;
        m_offer = 1'b1;
      end else if (take) begin
        m_live[m_ptr] = 1'b0;
        m_ptr   = (m_ptr + 1) % N;
        m_offer = 1'b0;
      end
      if (we) begin
        m_mem[a]  = d;
        m_live[a] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, rdy);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 0, '0, 1'b0);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    model_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Single word: presented two cycles after the write.
    step(1'b0, 1'b1, 0, 64'd1, 1'b1);
    check("first_count", 64'(count), 64'd1);
    step(1'b0, 1'b0, 0, '0, 1'b1);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_data", out_data, 64'd1);
    idle(3, 1'b1);
    check("first_drained", 64'(count), 64'd0);

    // Fill every slot in order while draining; the pointer wraps.
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, i, 64'd1 << i, 1'b1);
    idle(2 * N + 4, 1'b1);
    check("fill_count", 64'(count), 64'd0);
    check("fill_ptr", 64'(out_idx), 64'd1);
    check("fill_flags", 64'({err_pattern, err_overwrite}), 64'd0);

    // Bad pattern at slot 0: flag rises with out_valid and sticks.
    do_reset();
    step(1'b0, 1'b1, 0, 64'd2, 1'b0);
    idle(1, 1'b0);
    check("pat_flag", 64'(err_pattern), 64'd1);
    check("pat_data", out_data, 64'd2);
    idle(6, 1'b1);
    check("pat_sticky", 64'(err_pattern), 64'd1);

    // Double write to slot 5 while the reader is stuck at empty slot 0.
    do_reset();
    step(1'b0, 1'b1, 5, 64'd1 << 5, 1'b1);
    step(1'b0, 1'b1, 5, 64'd1 << 5, 1'b1);
    check("ovw_flag", 64'(err_overwrite), 64'd1);
    check("ovw_count", 64'(count), 64'd1);
    idle(3, 1'b1);

    // Stall at slot 3, then consume while rewriting slot 3.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, 64'd1 << i, 1'b1);
    guard = 0;
    while (!(m_offer && m_ptr == 3) && guard < 50) begin
      step(1'b0, 1'b0, 0, '0, 1'b1);
      guard++;
    end
    check("stall_reached", 64'(guard < 50), 64'd1);
    idle(3, 1'b0);
    step(1'b0, 1'b1, 3, 64'd1 << 3, 1'b1);
    check("same_slot_ovw", 64'(err_overwrite), 64'd0);
    check("same_slot_count", 64'(count), 64'd1);
    idle(6, 1'b0);

    // Reset while offering with four live slots, then a fresh write.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, 64'd1 << i, 1'b0);
    idle(2, 1'b0);
    check("pre_rst_count", 64'(count), 64'd4);
    do_reset();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    step(1'b0, 1'b1, 0, 64'd1, 1'b0);
    step(1'b0, 1'b0, 0, '0, 1'b0);
    check("rst_rewrite", 64'(out_valid), 64'd1);
    idle(2, 1'b1);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit            we;
      int            a;
      logic [DW-1:0] d;
      we = ($urandom_range(0, 9) < 4);
      a  = ($urandom_range(0, 3) == 0) ? m_ptr : int'($urandom_range(0, N - 1));
      d  = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : (64'd1 << a);
      step(($urandom_range(0, 599) == 0), we, a, d, ($urandom_range(0, 9) < 7));
    end
    idle(4, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
